multicycle_controller: RTL and testbench
========================================

# multicycle_controller

- Control unit for the multicycle ARM datapath.
- Decodes the registered instruction and sequences fetch / decode / execute / memory / writeback through a Moore main FSM.
- Produces all datapath mux selects and write enables, plus the memory write strobe.
- Holds the NZCV flags and gates architectural writes with the condition check.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears the state register, flags and condition flop.
- Instr  in  20  Instr[31:12] from the instruction register: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12].
- ALUFlags  in  4  NZCV from the ALU, current cycle.
- PCWrite  out  1  PC register enable.
- MemWrite  out  1  data memory write strobe.
- RegWrite  out  1  register file write enable.
- IRWrite  out  1  instruction register enable.
- AdrSrc  out  1  0=PC, 1=Result.
- RegSrc  out  2  [0]=1 selects RA1=R15; [1]=1 selects RA2=Rd.
- ALUSrcA  out  2  00=A, 01=PC, 10=ALUOut.
- ALUSrcB  out  2  00=WriteData, 01=ExtImm, 10=constant 4.
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- ImmSrc  out  2  equals Op.
- ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR.

## Operation
- Main FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN.
- Transitions:
  - FETCH→DECODE.
  - DECODE→EXECUTEI if Op=00 and Funct[5]=1; EXECUTER if Op=00 and Funct[5]=0; MEMADR if Op=01; BRANCH if Op=10; UNKNOWN if Op=11.
  - MEMADR→MEMREAD if Funct[0]=1, else MEMWRITE.
  - MEMREAD→MEMWB.
  - EXECUTER / EXECUTEI→ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH, UNKNOWN→FETCH.
- Per-state outputs (every field not listed is 0):
  - FETCH: IRWrite=1, NextPC=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUOp=0.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUOp=0.
  - MEMADR: ALUSrcB=01, ALUOp=0.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, MemW=1.
  - EXECUTER: ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1.
  - ALUWB: RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, ALUOp=0, Branch=1.
  - UNKNOWN: all outputs 0.
- Instruction decode (combinational):
  - RegSrc = {Op==01, Op==10}.
  - ImmSrc = Op.
- ALU decode:
  - ALUOp=0 → ALUControl=00, FlagW=00.
  - ALUOp=1: Funct[4:1] 0100→00, 0010→01, 0000→10, 1100→11; any other value→00 with FlagW=00.
  - FlagW[1] = Funct[0] (S bit).
  - FlagW[0] = Funct[0] & (ALUControl is 00 or 01).
- Condition check, using the stored Flags (NZCV):
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !(C&!Z); GE N==V; LT N!=V; GT !Z&(N==V); LE its complement.
  - AL (1110) → 1; 1111 → 0.
- Flag registers:
  - Flags[3:2] load ALUFlags[3:2] when FlagW[1]&CondEx.
  - Flags[1:0] load ALUFlags[1:0] when FlagW[0]&CondEx.
- CondExDelayed: a flop that captures CondEx every cycle.
- Gated enables:
  - PCS = Branch | (RegW & Rd==1111).
  - RegWrite = RegW & CondExDelayed.
  - MemWrite = MemW & CondExDelayed.
  - PCWrite = (PCS & CondExDelayed) | NextPC.

## Timing
- State, Flags and CondExDelayed update on the rising edge of clk.
- All outputs are combinational from state and Instr (Moore + decode); no output register.
- Instruction latency from FETCH entry to the next FETCH:
  - B and undefined: 3 cycles.
  - Data-processing and STR: 4 cycles.
  - LDR: 5 cycles.
- Flags written in EXECUTE are visible to the condition check from the next cycle onward, i.e. to the following instruction.
- CondExDelayed evaluated in EXECUTE/MEMADR gates the writeback one cycle later, so a flag update in EXECUTE cannot cancel its own writeback.
- Reset asserted at any time:
  - state→FETCH, Flags→0000, CondExDelayed→0, effective immediately without waiting for a clock edge.
  - While reset is high, outputs show FETCH values: IRWrite=1, PCWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, AdrSrc=0, RegWrite=0, MemWrite=0.
- First FETCH occurs on the first edge after reset deasserts.

## Test plan
- **ADD R2,R3,R4** (0xE0832004) after reset:
  - States FETCH, DECODE, EXECUTER, ALUWB, then FETCH in cycle 5.
  - ALUControl=00 in EXECUTER.
  - RegWrite=1 only in ALUWB; Flags unchanged.
- **SUBS R1,R1,#1** (0xE2511001) with ALUFlags=0100 in EXECUTEI, then **BEQ** (0x0A000002):
  - SUBS: ALUSrcB=01, ALUControl=01; Flags become 0100.
  - BEQ: takes BRANCH with PCWrite=1, ResultSrc=10.
- **ADDNE** (0x10832004) with Flags Z=1:
  - RegWrite=0 in ALUWB; PCWrite=0 outside FETCH; Flags unchanged.
  - Repeat with Z=0: RegWrite=1.
- **LDR R5,[R0,#8]** (0xE5905008):
  - States MEMADR, MEMREAD, MEMWB.
  - AdrSrc=1 in MEMREAD; ResultSrc=01 and RegWrite=1 in MEMWB.
- **STR** (0xE5805008):
  - MEMWRITE with MemWrite=1, AdrSrc=1; 4 cycles total.
  - **LDR to PC** (Rd=1111): PCWrite=1 in MEMWB.
- **Reset and undefined opcode:**
  - Reset asserted mid-MEMREAD: same-cycle state FETCH, Flags=0000, RegWrite=MemWrite=0.
  - Op=11 (0xEC000000): UNKNOWN with all enables 0, then FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control unit for the multicycle ARM datapath. A Moore main FSM steps each
//   instruction through fetch / decode / execute / memory / writeback, and a
//   combinational decoder turns the FSM state plus the registered instruction
//   into the datapath mux selects and write enables. The NZCV flags live here,
//   and the condition check gates every architectural write.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high; clears state, flags and condExDelayed
//   Instr       Instr[31:12]: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]
//   ALUFlags    NZCV from the ALU in the current cycle
//   PCWrite     PC register enable
//   MemWrite    data memory write strobe
//   RegWrite    register file write enable
//   IRWrite     instruction register enable
//   AdrSrc      memory address select: 0 = PC, 1 = Result
//   RegSrc      [0] selects RA1 = R15, [1] selects RA2 = Rd
//   ALUSrcA     00 = A, 01 = PC, 10 = ALUOut
//   ALUSrcB     00 = WriteData, 01 = ExtImm, 10 = constant 4
//   ResultSrc   00 = ALUOut, 01 = Data, 10 = ALUResult
//   ImmSrc      immediate extension format, equal to Op
//   ALUControl  00 = ADD, 01 = SUB, 10 = AND, 11 = ORR

module multicycle_controller (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  output logic         PCWrite,
  output logic         MemWrite,
  output logic         RegWrite,
  output logic         IRWrite,
  output logic         AdrSrc,
  output logic [1:0]   RegSrc,
  output logic [1:0]   ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ResultSrc,
  output logic [1:0]   ImmSrc,
  output logic [1:0]   ALUControl
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN
  } stateT;

  stateT       state;
  stateT       nextState;

  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd;
  logic        unusedRn;

  logic        nextPc;
  logic        branch;
  logic        regW;
  logic        memW;
  logic        aluOp;
  logic [1:0]  flagW;
  logic        condEx;
  logic        condExDelayed;
  logic        pcs;
  logic [3:0]  flags;

  assign cond     = Instr[31:28];
  assign op       = Instr[27:26];
  assign funct    = Instr[25:20];
  assign rd       = Instr[15:12];
  // Rn is consumed by the datapath only; the controller never looks at it.
  assign unusedRn = ^Instr[19:16];

  // State register. Reset forces FETCH asynchronously so the outputs show
  // fetch values for as long as reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= nextState;
  end

  // Next-state logic. DECODE fans out on the instruction class; every
  // terminal state returns to FETCH.
  always_comb begin
    nextState = FETCH;
    case (state)
      FETCH:    nextState = DECODE;
      DECODE: begin
        case (op)
          2'b00:   nextState = funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   nextState = MEMADR;
          2'b10:   nextState = BRANCH;
          default: nextState = UNKNOWN;
        endcase
      end
      MEMADR:   nextState = funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  nextState = MEMWB;
      EXECUTER: nextState = ALUWB;
      EXECUTEI: nextState = ALUWB;
      default:  nextState = FETCH;
    endcase
  end

  // Moore outputs of the main FSM. The write enables here are the ungated
  // requests; the condition check is applied further down.
  always_comb begin
    IRWrite   = 1'b0;
    nextPc    = 1'b0;
    AdrSrc    = 1'b0;
    regW      = 1'b0;
    memW      = 1'b0;
    branch    = 1'b0;
    aluOp     = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        nextPc    = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        regW      = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        memW   = 1'b1;
      end
      EXECUTER: aluOp = 1'b1;
      EXECUTEI: begin
        ALUSrcB = 2'b01;
        aluOp   = 1'b1;
      end
      ALUWB:    regW = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU decode. Only ADD/SUB touch C and V; unsupported commands fall back
  // to ADD and are not allowed to disturb the flags at all.
  always_comb begin
    ALUControl = 2'b00;
    flagW      = 2'b00;
    if (aluOp) begin
      case (funct[4:1])
        4'b0100: begin ALUControl = 2'b00; flagW = {funct[0], funct[0]}; end
        4'b0010: begin ALUControl = 2'b01; flagW = {funct[0], funct[0]}; end
        4'b0000: begin ALUControl = 2'b10; flagW = {funct[0], 1'b0};     end
        4'b1100: begin ALUControl = 2'b11; flagW = {funct[0], 1'b0};     end
        default: begin ALUControl = 2'b00; flagW = 2'b00;                end
      endcase
    end
  end

  assign RegSrc = {op == 2'b01, op == 2'b10};
  assign ImmSrc = op;

  // Condition check against the stored NZCV flags (flags[3]=N .. flags[0]=V).
  always_comb begin
    condEx = 1'b0;
    case (cond)
      4'b0000: condEx = flags[2];
      4'b0001: condEx = ~flags[2];
      4'b0010: condEx = flags[1];
      4'b0011: condEx = ~flags[1];
      4'b0100: condEx = flags[3];
      4'b0101: condEx = ~flags[3];
      4'b0110: condEx = flags[0];
      4'b0111: condEx = ~flags[0];
      4'b1000: condEx = flags[1] & ~flags[2];
      4'b1001: condEx = ~(flags[1] & ~flags[2]);
      4'b1010: condEx = (flags[3] == flags[0]);
      4'b1011: condEx = (flags[3] != flags[0]);
      4'b1100: condEx = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: condEx = ~(~flags[2] & (flags[3] == flags[0]));
      4'b1110: condEx = 1'b1;
      default: condEx = 1'b0;
    endcase
  end

  // Flag storage and the delayed condition. condExDelayed is sampled in the
  // execute/address cycle so the writeback one cycle later is judged on the
  // flags that existed before this instruction could modify them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags         <= 4'b0000;
      condExDelayed <= 1'b0;
    end else begin
      if (flagW[1] & condEx) flags[3:2] <= ALUFlags[3:2];
      if (flagW[0] & condEx) flags[1:0] <= ALUFlags[1:0];
      condExDelayed <= condEx;
    end
  end

  // A write to R15 is a PC write, so it is steered to PCWrite alongside branches.
  assign pcs      = branch | (regW & (rd == 4'b1111));
  assign RegWrite = regW & condExDelayed;
  assign MemWrite = memW & condExDelayed;
  assign PCWrite  = (pcs & condExDelayed) | nextPc;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
//   Self-checking bench for multicycle_controller. A reference model of the
//   controller (state, flags, delayed condition) produces the expected output
//   vector for every cycle; expected and observed vectors are queued as the
//   stimulus runs and each test task drains and compares them.

module tb_multicycle_controller;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:12] Instr;
  logic [3:0]   ALUFlags;
  logic         PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]   RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
  logic [16:0]  dutVec;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .RegSrc     (RegSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl)
  );

  assign dutVec = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
                   ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};

  always #5 clk = ~clk;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3,
                 S_MEMWB = 4, S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7,
                 S_ALUWB = 8, S_BRANCH = 9, S_UNKNOWN = 10;

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  fl;
    int          lat;
  } stepT;

  int          nChecks = 0;
  int          nFails  = 0;
  logic [16:0] expQ[$];
  logic [16:0] obsQ[$];

  int          mState;
  logic [3:0]  mFlags;
  logic        mCd;

  // Reference condition check on NZCV.
  function automatic logic condCheck(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !(cy && !z);
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return !(!z && (n == v));
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Reference output vector for a given state, instruction and delayed condition.
  function automatic logic [16:0] modelOut(input int s, input logic [31:12] ins, input logic cd);
    logic [1:0] op, srcA, srcB, resSrc, aluCtl;
    logic [5:0] fn;
    logic       ir, npc, adr, rw, mw, br, aop, pcs;
    op = ins[27:26];
    fn = ins[25:20];
    {ir, npc, adr, rw, mw, br, aop} = 7'b0;
    srcA = 2'b00; srcB = 2'b00; resSrc = 2'b00;
    case (s)
      S_FETCH:    begin ir = 1; npc = 1; srcA = 2'b01; srcB = 2'b10; resSrc = 2'b10; end
      S_DECODE:   begin srcA = 2'b01; srcB = 2'b10; resSrc = 2'b10; end
      S_MEMADR:   srcB = 2'b01;
      S_MEMREAD:  adr = 1;
      S_MEMWB:    begin resSrc = 2'b01; rw = 1; end
      S_MEMWRITE: begin adr = 1; mw = 1; end
      S_EXECR:    aop = 1;
      S_EXECI:    begin srcB = 2'b01; aop = 1; end
      S_ALUWB:    rw = 1;
      S_BRANCH:   begin srcB = 2'b01; resSrc = 2'b10; br = 1; end
      default: ;
    endcase
    aluCtl = 2'b00;
    if (aop) begin
      case (fn[4:1])
        4'b0010: aluCtl = 2'b01;
        4'b0000: aluCtl = 2'b10;
        4'b1100: aluCtl = 2'b11;
        default: aluCtl = 2'b00;
      endcase
    end
    pcs = br | (rw & (ins[15:12] == 4'hF));
    return {(pcs & cd) | npc, mw & cd, rw & cd, ir, adr, op == 2'b01, op == 2'b10,
            srcA, srcB, resSrc, op, aluCtl};
  endfunction

  function automatic logic [1:0] modelFlagW(input int s, input logic [5:0] fn);
    if (s != S_EXECR && s != S_EXECI) return 2'b00;
    case (fn[4:1])
      4'b0100, 4'b0010: return {fn[0], fn[0]};
      4'b0000, 4'b1100: return {fn[0], 1'b0};
      default:          return 2'b00;
    endcase
  endfunction

  function automatic int modelNext(input int s, input logic [31:12] ins);
    case (s)
      S_FETCH:  return S_DECODE;
      S_DECODE: begin
        case (ins[27:26])
          2'b00:   return ins[25] ? S_EXECI : S_EXECR;
          2'b01:   return S_MEMADR;
          2'b10:   return S_BRANCH;
          default: return S_UNKNOWN;
        endcase
      end
      S_MEMADR:  return ins[20] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: return S_MEMWB;
      S_EXECR, S_EXECI: return S_ALUWB;
      default:   return S_FETCH;
    endcase
  endfunction

  task automatic modelReset();
    mState = S_FETCH;
    mFlags = 4'b0000;
    mCd    = 1'b0;
  endtask

  // Computes the model's next state from the inputs present now, then commits
  // it at the rising edge together with the DUT.
  task automatic advanceModel();
    int         ns;
    logic [3:0] nf;
    logic [1:0] fw;
    logic       ce;
    ce = condCheck(Instr[31:28], mFlags);
    fw = modelFlagW(mState, Instr[25:20]);
    ns = modelNext(mState, Instr);
    nf = mFlags;
    if (fw[1] && ce) nf[3:2] = ALUFlags[3:2];
    if (fw[0] && ce) nf[1:0] = ALUFlags[1:0];
    @(posedge clk);
    if (!reset) begin
      mState = ns;
      mFlags = nf;
      mCd    = ce;
    end
  endtask

  // Drives one instruction from its FETCH cycle until the DUT raises IRWrite
  // again. Called just after a falling edge while in FETCH. Every cycle queues
  // the model's expected vector and the DUT's observed vector; lat returns the
  // observed cycle count, or -1 if the DUT never came back to FETCH.
  task automatic applyStimulus(input logic [31:0] ins, input logic [3:0] fl, output int lat);
    int   cyc;
    logic done;
    Instr    = ins[31:12];
    ALUFlags = fl;
    #1;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 10) begin
      if (cyc > 0) begin
        @(negedge clk);
        #1;
      end
      if (cyc > 0 && IRWrite === 1'b1) begin
        done = 1'b1;
      end else begin
        expQ.push_back(modelOut(mState, Instr, mCd));
        obsQ.push_back(dutVec);
        advanceModel();
        cyc++;
      end
    end
    lat = done ? cyc : -1;
  endtask

  task automatic test_reset();
    logic [16:0] e;
    reset    = 1'b0;
    Instr    = 20'hE0832;
    ALUFlags = 4'b0000;
    #2 reset = 1'b1;
    #1;
    modelReset();
    e = modelOut(mState, Instr, mCd);
    nChecks++;
    if (dutVec !== e) begin
      nFails++;
      $display("[TB] FAIL reset_state: got %h expected %h", dutVec, e);
    end
    @(negedge clk);
    #1;
    e = modelOut(mState, Instr, mCd);
    nChecks++;
    if (dutVec !== e) begin
      nFails++;
      $display("[TB] FAIL reset_hold: got %h expected %h", dutVec, e);
    end
    reset = 1'b0;
  endtask

  task automatic test_add();
    int lat;
    logic [16:0] e, o;
    applyStimulus(32'hE0832004, 4'b1111, lat);
    nChecks++;
    if (lat !== 4) begin
      nFails++;
      $display("[TB] FAIL add_latency: got %0d expected 4", lat);
    end
    for (int k = 0; expQ.size() > 0; k++) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); nChecks++;
      if (o !== e) begin nFails++; $display("[TB] FAIL add cycle %0d: got %h expected %h", k, o, e); end
    end
  endtask

  task automatic test_subs_beq();
    stepT seq [3];
    int lat;
    logic [16:0] e, o;
    seq = '{'{32'hE2511001, 4'b0100, 4}, '{32'h0A000002, 4'b0000, 3}, '{32'h1A000002, 4'b0000, 3}};
    foreach (seq[i]) begin
      applyStimulus(seq[i].ins, seq[i].fl, lat);
      nChecks++;
      if (lat !== seq[i].lat) begin
        nFails++;
        $display("[TB] FAIL subs_beq_latency step %0d: got %0d expected %0d", i, lat, seq[i].lat);
      end
    end
    for (int k = 0; expQ.size() > 0; k++) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); nChecks++;
      if (o !== e) begin nFails++; $display("[TB] FAIL subs_beq cycle %0d: got %h expected %h", k, o, e); end
    end
  endtask

  task automatic test_cond_exec();
    stepT seq [3];
    int lat;
    logic [16:0] e, o;
    // Z is set on entry; ADDNE is suppressed, SUBS clears Z, ADDNE then writes.
    seq = '{'{32'h10832004, 4'b0000, 4}, '{32'hE2511001, 4'b0010, 4}, '{32'h10832004, 4'b0100, 4}};
    foreach (seq[i]) begin
      applyStimulus(seq[i].ins, seq[i].fl, lat);
      nChecks++;
      if (lat !== seq[i].lat) begin
        nFails++;
        $display("[TB] FAIL cond_exec_latency step %0d: got %0d expected %0d", i, lat, seq[i].lat);
      end
    end
    for (int k = 0; expQ.size() > 0; k++) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); nChecks++;
      if (o !== e) begin nFails++; $display("[TB] FAIL cond_exec cycle %0d: got %h expected %h", k, o, e); end
    end
  endtask

  task automatic test_memory();
    stepT seq [3];
    int lat;
    logic [16:0] e, o;
    seq = '{'{32'hE5905008, 4'b0000, 5}, '{32'hE5805008, 4'b0000, 4}, '{32'hE590F008, 4'b0000, 5}};
    foreach (seq[i]) begin
      applyStimulus(seq[i].ins, seq[i].fl, lat);
      nChecks++;
      if (lat !== seq[i].lat) begin
        nFails++;
        $display("[TB] FAIL memory_latency step %0d: got %0d expected %0d", i, lat, seq[i].lat);
      end
    end
    for (int k = 0; expQ.size() > 0; k++) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); nChecks++;
      if (o !== e) begin nFails++; $display("[TB] FAIL memory cycle %0d: got %h expected %h", k, o, e); end
    end
  endtask

  task automatic test_alu_decode();
    stepT seq [13];
    int lat;
    logic [16:0] e, o;
    // AND/SUB/ORR/ADD-to-PC, ADDS, then partial flag writes: ANDS may only
    // touch N/Z, EORS (unsupported) touches nothing; branches observe them.
    seq = '{'{32'hE0032004, 4'b0000, 4}, '{32'hE0432004, 4'b0000, 4},
            '{32'hE1832004, 4'b0000, 4}, '{32'hE083F004, 4'b0000, 4},
            '{32'hE0932004, 4'b1010, 4}, '{32'hE2511001, 4'b0011, 4},
            '{32'hE0132004, 4'b1100, 4}, '{32'hE0332004, 4'b0000, 4},
            '{32'h0A000002, 4'b0000, 3}, '{32'h2A000002, 4'b0000, 3},
            '{32'h6A000002, 4'b0000, 3}, '{32'h4A000002, 4'b0000, 3},
            '{32'hDA000002, 4'b0000, 3}};
    foreach (seq[i]) begin
      applyStimulus(seq[i].ins, seq[i].fl, lat);
      nChecks++;
      if (lat !== seq[i].lat) begin
        nFails++;
        $display("[TB] FAIL alu_decode_latency step %0d: got %0d expected %0d", i, lat, seq[i].lat);
      end
    end
    for (int k = 0; expQ.size() > 0; k++) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); nChecks++;
      if (o !== e) begin nFails++; $display("[TB] FAIL alu_decode cycle %0d: got %h expected %h", k, o, e); end
    end
  endtask

  task automatic test_cond_codes();
    logic [3:0] pats [8];
    int lat;
    logic [16:0] e, o;
    pats = '{4'b0000, 4'b0100, 4'b1000, 4'b1001, 4'b0010, 4'b0110, 4'b0001, 4'b1101};
    foreach (pats[p]) begin
      applyStimulus(32'hE2511001, pats[p], lat);
      for (int c = 0; c < 16; c++) begin
        applyStimulus({c[3:0], 28'hA000002}, 4'b0000, lat);
        nChecks++;
        if (lat !== 3) begin
          nFails++;
          $display("[TB] FAIL cond_codes_latency flags %b cond %0d: got %0d expected 3", pats[p], c, lat);
        end
      end
      for (int k = 0; expQ.size() > 0; k++) begin
        e = expQ.pop_front(); o = obsQ.pop_front(); nChecks++;
        if (o !== e) begin nFails++; $display("[TB] FAIL cond_codes flags %b cycle %0d: got %h expected %h", pats[p], k, o, e); end
      end
    end
  endtask

  task automatic test_reset_midmemread();
    int lat;
    logic [16:0] e, o;
    applyStimulus(32'hE2511001, 4'b0100, lat);
    Instr    = 20'hE5905;
    ALUFlags = 4'b0000;
    #1;
    for (int c = 0; c < 3; c++) begin
      expQ.push_back(modelOut(mState, Instr, mCd));
      obsQ.push_back(dutVec);
      advanceModel();
      @(negedge clk);
      #1;
    end
    expQ.push_back(modelOut(mState, Instr, mCd));
    obsQ.push_back(dutVec);
    #2 reset = 1'b1;
    #1;
    modelReset();
    expQ.push_back(modelOut(mState, Instr, mCd));
    obsQ.push_back(dutVec);
    @(negedge clk);
    #1;
    expQ.push_back(modelOut(mState, Instr, mCd));
    obsQ.push_back(dutVec);
    reset = 1'b0;
    // Flags were cleared, so this BEQ must not branch.
    applyStimulus(32'h0A000002, 4'b0000, lat);
    nChecks++;
    if (lat !== 3) begin
      nFails++;
      $display("[TB] FAIL reset_midmemread_latency: got %0d expected 3", lat);
    end
    for (int k = 0; expQ.size() > 0; k++) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); nChecks++;
      if (o !== e) begin nFails++; $display("[TB] FAIL reset_midmemread cycle %0d: got %h expected %h", k, o, e); end
    end
  endtask

  task automatic test_undefined();
    int lat;
    logic [16:0] e, o;
    applyStimulus(32'hEC000000, 4'b1111, lat);
    nChecks++;
    if (lat !== 3) begin
      nFails++;
      $display("[TB] FAIL undefined_latency: got %0d expected 3", lat);
    end
    applyStimulus(32'hE0832004, 4'b0000, lat);
    nChecks++;
    if (lat !== 4) begin
      nFails++;
      $display("[TB] FAIL after_undefined_latency: got %0d expected 4", lat);
    end
    for (int k = 0; expQ.size() > 0; k++) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); nChecks++;
      if (o !== e) begin nFails++; $display("[TB] FAIL undefined cycle %0d: got %h expected %h", k, o, e); end
    end
  endtask

  // Watchdog so a stuck run still terminates with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_add();
    test_subs_beq();
    test_cond_exec();
    test_memory();
    test_alu_decode();
    test_cond_codes();
    test_reset_midmemread();
    test_undefined();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
